// File: rtl/cordic_pkg.sv
// cordic_pkg: shared state/mode types and index-width helper for the CORDIC iteration controller.
package cordic_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, ITER, SCALE, DONE} cordic_state_t;
    typedef enum logic {ROTATION, VECTORING} cordic_mode_t;
    localparam int CORDIC_N_ITER = 8;
    function automatic int cordic_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
    localparam int CORDIC_IDX_W = cordic_idx_w(CORDIC_N_ITER);
endpackage

// File: rtl/cordic_skip_mon.sv
// cordic_skip_mon: counts no-rotate cycles, saturating at MAX_SKIP+1, with a sticky error flag.
module cordic_skip_mon #(
    parameter int MAX_SKIP = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic err
);
    localparam int CW = $clog2(MAX_SKIP + 2);
    localparam logic [CW-1:0] SAT = CW'(MAX_SKIP + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    always_comb begin
        cnt_d = clr ? '0 : (inc && cnt_q != SAT) ? cnt_q + 1'b1 : cnt_q;
        err_d = clr ? 1'b0 : (err_q | (cnt_d == SAT));
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
endmodule

// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: sequences load, N_ITER micro-rotations and completion for the CORDIC datapath.
// Define CORDIC_ITER_CTRL_SCALE_EN to add a one-cycle gain-compensation SCALE state and scale_en output.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int N_ITER   = 8,
    parameter int MAX_SKIP = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      mode,
    input  logic                      d,
    input  logic                      dn,
    output logic                      ld_operands,
    output logic                      rot_en,
    output logic                      rot_dir,
    output logic [$clog2(N_ITER)-1:0] shift_amt,
    output logic                      mode_q,
    output logic                      busy,
    output logic                      done,
    output logic [N_ITER-1:0]         dir_hist,
    output logic                      err_skip
`ifdef CORDIC_ITER_CTRL_SCALE_EN
    ,
    output logic                      scale_en
`endif
);
    localparam int IW = cordic_idx_w(N_ITER);
    localparam logic [IW-1:0] LAST = IW'(N_ITER - 1);
`ifdef CORDIC_ITER_CTRL_SCALE_EN
    localparam cordic_state_t POST_ITER = SCALE;
`else
    localparam cordic_state_t POST_ITER = DONE;
`endif
    cordic_state_t state_q, state_d;
    cordic_mode_t mode_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N_ITER-1:0] hist_q, hist_d;
    logic ld_q, ld_d, busy_q, busy_d, done_q, done_d;
    logic in_iter;
`ifdef CORDIC_ITER_CTRL_SCALE_EN
    logic scale_q, scale_d;
`endif
    assign in_iter = state_q == ITER;
    // abort overrides every transition; reset is handled ahead of it in the register block
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? LOAD : IDLE;
            LOAD:    state_d = ITER;
            ITER:    state_d = (idx_q == LAST) ? POST_ITER : ITER;
            SCALE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
        idx_d  = in_iter ? idx_q + 1'b1 : '0;
        hist_d = hist_q;
        if (state_q == LOAD) hist_d = '0;
        else if (in_iter && !abort) hist_d[idx_q] = d & ~dn;
        mode_d = (state_q == IDLE && start && !abort) ? cordic_mode_t'(mode) : cordic_mode_t'(mode_q);
        ld_d   = state_d == LOAD;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
`ifdef CORDIC_ITER_CTRL_SCALE_EN
        scale_d = state_d == SCALE;
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hist_q  <= '0;
            mode_q  <= 1'b0;
            ld_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CORDIC_ITER_CTRL_SCALE_EN
            scale_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hist_q  <= hist_d;
            mode_q  <= mode_d;
            ld_q    <= ld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef CORDIC_ITER_CTRL_SCALE_EN
            scale_q <= scale_d;
`endif
        end
    end
    cordic_skip_mon #(.MAX_SKIP(MAX_SKIP)) u_skip_mon (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state_q == LOAD),
        .inc  (in_iter & dn & ~abort),
        .err  (err_skip)
    );
    assign ld_operands = ld_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dir_hist    = hist_q;
    assign rot_en      = in_iter & ~dn;
    assign rot_dir     = in_iter & d & ~dn;
    assign shift_amt   = in_iter ? idx_q : '0;
`ifdef CORDIC_ITER_CTRL_SCALE_EN
    assign scale_en    = scale_q;
`endif
endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// tb_cordic_iter_ctrl: directed scenarios plus random traffic against a position-based reference model.
module tb_cordic_iter_ctrl;
    localparam int N = 8;
    localparam int MAX_SKIP = 3;
`ifdef CORDIC_ITER_CTRL_SCALE_EN
    localparam int SC = 1;
`else
    localparam int SC = 0;
`endif
    localparam int LASTP = N + 1 + SC;
    logic clk = 0, rst_n = 0, start = 0, abort = 0, mode = 0, d = 0, dn = 0;
    logic ld_operands, rot_en, rot_dir, mode_q, busy, done, err_skip;
    logic [2:0] shift_amt;
    logic [N-1:0] dir_hist;
`ifdef CORDIC_ITER_CTRL_SCALE_EN
    logic scale_en;
`endif
    int vectors = 0, miscompares = 0;
    // model: pos = -1 idle, 0 load, 1..N iteration pos-1, then optional scale, then done
    int pos = -1, m_skip = 0;
    logic [N-1:0] m_hist = '0;
    logic m_err = 0, m_mode = 0;

    cordic_iter_ctrl #(.N_ITER(N), .MAX_SKIP(MAX_SKIP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .d(d), .dn(dn),
        .ld_operands(ld_operands), .rot_en(rot_en), .rot_dir(rot_dir), .shift_amt(shift_amt),
        .mode_q(mode_q), .busy(busy), .done(done), .dir_hist(dir_hist), .err_skip(err_skip)
`ifdef CORDIC_ITER_CTRL_SCALE_EN
        , .scale_en(scale_en)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            pos = -1; m_hist = '0; m_skip = 0; m_err = 0; m_mode = 0;
        end else begin
            if (pos == 0) begin
                m_hist = '0; m_skip = 0; m_err = 0;
            end
            if (pos >= 1 && pos <= N && !abort) begin
                m_hist[pos-1] = d & ~dn;
                if (dn && m_skip <= MAX_SKIP) m_skip++;
                if (m_skip > MAX_SKIP) m_err = 1;
            end
            if (abort) pos = -1;
            else if (pos < 0) begin
                if (start) begin
                    pos = 0; m_mode = mode;
                end
            end
            else if (pos == LASTP) pos = -1;
            else pos++;
        end
    endtask

    task automatic cycle(input logic s, input logic a, input logic r, input logic m, input logic dd, input logic ddn);
        logic iter;
        @(posedge clk);
        #1;
        start = s; abort = a; rst_n = r; mode = m; d = dd; dn = ddn;
        @(negedge clk);
        iter = pos >= 1 && pos <= N;
        check("ld_operands", 32'(ld_operands), 32'(pos == 0));
        check("busy", 32'(busy), 32'(pos >= 0));
        check("done", 32'(done), 32'(pos == LASTP));
        check("rot_en", 32'(rot_en), 32'(iter & ~dn));
        check("rot_dir", 32'(rot_dir), 32'(iter & d & ~dn));
        check("shift_amt", 32'(shift_amt), iter ? 32'(pos - 1) : 32'd0);
        check("mode_q", 32'(mode_q), 32'(m_mode));
        check("dir_hist", 32'(dir_hist), 32'(m_hist));
        check("err_skip", 32'(err_skip), 32'(m_err));
`ifdef CORDIC_ITER_CTRL_SCALE_EN
        check("scale_en", 32'(scale_en), 32'(pos == N + 1));
`endif
        model_step();
    endtask

    initial begin
        repeat (2) cycle(0, 0, 0, 0, 0, 0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hist", 32'(dir_hist), 32'd0);
        // basic operation, every iteration rotates negative
        for (int c = 0; c <= 11 + SC; c++) begin
            cycle(c == 0, 0, 1, 0, 1, 0);
            if (c == 1) check("t1_ld", 32'(ld_operands), 32'd1);
            if (c >= 2 && c <= 9) check("t1_shift", 32'(shift_amt), 32'(c - 2));
`ifdef CORDIC_ITER_CTRL_SCALE_EN
            if (c == 10) check("t1_scale", 32'(scale_en), 32'd1);
`endif
            if (c == 10 + SC) begin
                check("t1_done", 32'(done), 32'd1);
                check("t1_hist", 32'(dir_hist), 32'hFF);
            end
        end
        // hold cycles at idx 2 and 5, alternating direction
        for (int c = 0; c <= 11 + SC; c++) begin
            cycle(c == 0, 0, 1, 1, c >= 2 && (c - 2) % 2 == 0, c == 4 || c == 7);
            if (c == 4 || c == 7) check("t2_rot_en", 32'(rot_en), 32'd0);
            if (c == 11 + SC) begin
                check("t2_hist", 32'(dir_hist), 32'h51);
                check("t2_err", 32'(err_skip), 32'd0);
            end
        end
        // four holds in a row trip the skip error
        for (int c = 0; c <= 12 + SC; c++) begin
            cycle(c == 0, 0, 1, 0, 1, c >= 2 && c <= 5);
            if (c == 5) check("t3_err_before", 32'(err_skip), 32'd0);
            if (c == 6) check("t3_err_rise", 32'(err_skip), 32'd1);
            if (c == 12 + SC) check("t3_err_sticky", 32'(err_skip), 32'd1);
        end
        // abort at idx 4, then immediate restart
        for (int c = 0; c <= 18 + SC; c++) begin
            cycle(c == 0 || c == 7, c == 6, 1, 0, c[0], 0);
            if (c == 2) check("t4_err_clr", 32'(err_skip), 32'd0);
            if (c == 7) check("t4_busy", 32'(busy), 32'd0);
            if (c >= 7 && c < 17 + SC) check("t4_no_done", 32'(done), 32'd0);
            if (c == 17 + SC) check("t4_done", 32'(done), 32'd1);
        end
        // start held high: one op per idle visit
        for (int c = 0; c <= 14 + SC; c++) begin
            cycle(1, 0, 1, 1, 1, 0);
            if (c == 11 + SC) check("t5_idle", 32'(busy), 32'd0);
            if (c == 12 + SC) check("t5_reload", 32'(ld_operands), 32'd1);
        end
        repeat (12) cycle(0, 0, 1, 0, 0, 0);
        // reset at idx 6
        for (int c = 0; c <= 13; c++) begin
            cycle(c == 0, 0, c != 8, 0, 1, 0);
            if (c == 9) begin
                check("t6_busy", 32'(busy), 32'd0);
                check("t6_hist", 32'(dir_hist), 32'd0);
                check("t6_rot_en", 32'(rot_en), 32'd0);
            end
            if (c >= 9) check("t6_no_done", 32'(done), 32'd0);
        end
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3, $urandom_range(0, 99) != 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
